// File: rtl/frontend_cmd_definition_pkg.sv
// Shared command format between the frontend issue queue and the backend controller.
package frontend_cmd_definition_pkg;

    localparam int FE_ROW_BITS = 14;
    localparam int FE_COL_BITS = 10;

    typedef enum logic {
        OP_WRITE = 1'b0,
        OP_READ  = 1'b1
    } op_type_t;

    typedef struct packed {
        op_type_t                op_type;
        logic [FE_ROW_BITS-1:0]  row_addr;
        logic [FE_COL_BITS-1:0]  col_addr;
    } frontend_command_t;

    localparam int FRONTEND_CMD_BITS = $bits(frontend_command_t);

endpackage

// File: rtl/frontend_cmd_issue_queue_sync_fifo.sv
// First-word-fall-through synchronous FIFO; the head reads as zero while empty.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     i_rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             w_wr;
    logic             w_rd;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_count = r_count;
    assign o_rdata = o_empty ? '0 : r_mem[r_rptr];

    // A push while full is only accepted when the head leaves in the same cycle.
    assign w_rd = i_pop && !o_empty;
    assign w_wr = i_push && (!o_full || w_rd);

    always_ff @(posedge clk) begin
        if (w_wr)
            r_mem[r_wptr] <= i_wdata;
    end

    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr)
                r_wptr <= r_wptr + 1'b1;
            if (w_rd)
                r_rptr <= r_rptr + 1'b1;
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/frontend_cmd_issue_queue.sv
// In-order command issue to the backend with read-credit flow control on the return path.
module frontend_cmd_issue_queue
    import frontend_cmd_definition_pkg::*;
#(
    parameter int ROW_BITS   = FE_ROW_BITS,
    parameter int COL_BITS   = FE_COL_BITS,
    parameter int DATA_W     = 128,
    parameter int CMDQ_DEPTH = 8,
    parameter int RDQ_DEPTH  = 8
) (
    input  logic                           clk,
    input  logic                           power_on_rst_n,
    input  logic                           i_req_valid,
    output logic                           o_req_ready,
    input  logic                           i_req_op,
    input  logic [ROW_BITS-1:0]            i_req_row,
    input  logic [COL_BITS-1:0]            i_req_col,
    input  logic [DATA_W-1:0]              i_req_wdata,
    output logic                           o_frontend_command_valid,
    output logic [ROW_BITS+COL_BITS:0]     o_frontend_command,
    output logic [DATA_W-1:0]              o_frontend_write_data,
    input  logic                           i_backend_controller_ready,
    input  logic [DATA_W-1:0]              i_backend_read_data,
    input  logic                           i_backend_read_data_valid,
    output logic                           o_frontend_controller_ready,
    output logic [DATA_W-1:0]              o_rdata,
    output logic                           o_rdata_valid,
    input  logic                           i_rdata_ready,
    output logic [$clog2(RDQ_DEPTH):0]     o_outstanding_reads,
    output logic                           o_err_unexpected_rdata
);
    localparam int CMD_BITS = 1 + ROW_BITS + COL_BITS;
    localparam int CQW      = CMD_BITS + DATA_W;
    localparam int CQCW     = $clog2(CMDQ_DEPTH) + 1;
    localparam int OCW      = $clog2(RDQ_DEPTH) + 1;

    logic              r_ready_en;
    logic [OCW-1:0]    r_outstanding;
    logic              r_err;

    logic [CQW-1:0]    w_cmdq_rdata;
    logic              w_cmdq_full;
    logic              w_cmdq_empty;
    logic [CQCW-1:0]   w_cmdq_count;
    logic              w_cmd_push;
    logic              w_issue;
    op_type_t          w_head_op;

    logic [DATA_W-1:0] w_rdq_rdata;
    logic              w_rdq_full;
    logic              w_rdq_empty;
    logic [OCW-1:0]    w_rdq_count;
    logic              w_rdq_push;
    logic              w_rdq_pop;
    logic [OCW:0]      w_rd_committed;
    logic              w_credit_ok;
    logic              w_rd_issue;

    // Readies stay low for the reset cycle and rise one cycle after release.
    always_ff @(posedge clk) begin
        if (!power_on_rst_n)
            r_ready_en <= 1'b0;
        else
            r_ready_en <= 1'b1;
    end

    assign o_req_ready = r_ready_en && !w_cmdq_full;
    assign w_cmd_push  = i_req_valid && o_req_ready;

    sync_fifo #(.WIDTH(CQW), .DEPTH(CMDQ_DEPTH)) u_cmdq (
        .clk     (clk),
        .i_rst_n (power_on_rst_n),
        .i_push  (w_cmd_push),
        .i_wdata ({i_req_op, i_req_row, i_req_col, i_req_wdata}),
        .i_pop   (w_issue),
        .o_rdata (w_cmdq_rdata),
        .o_full  (w_cmdq_full),
        .o_empty (w_cmdq_empty),
        .o_count (w_cmdq_count)
    );

    assign w_head_op      = op_type_t'(w_cmdq_rdata[CQW-1]);
    assign w_rd_committed = {1'b0, w_rdq_count} + {1'b0, r_outstanding};
    assign w_credit_ok    = (w_rd_committed < (OCW+1)'(RDQ_DEPTH));

    // A read head without credit also holds back every younger command.
    assign o_frontend_command_valid = !w_cmdq_empty && (w_cmdq_count != '0) &&
                                      (w_head_op == OP_WRITE || w_credit_ok);
    assign o_frontend_command       = w_cmdq_rdata[CQW-1:DATA_W];
    assign o_frontend_write_data    = w_cmdq_rdata[DATA_W-1:0];
    assign w_issue    = o_frontend_command_valid && i_backend_controller_ready;
    assign w_rd_issue = w_issue && (w_head_op == OP_READ);

    assign w_rdq_push = i_backend_read_data_valid && (r_outstanding != '0);
    assign w_rdq_pop  = o_rdata_valid && i_rdata_ready;

    sync_fifo #(.WIDTH(DATA_W), .DEPTH(RDQ_DEPTH)) u_rdq (
        .clk     (clk),
        .i_rst_n (power_on_rst_n),
        .i_push  (w_rdq_push),
        .i_wdata (i_backend_read_data),
        .i_pop   (w_rdq_pop),
        .o_rdata (w_rdq_rdata),
        .o_full  (w_rdq_full),
        .o_empty (w_rdq_empty),
        .o_count (w_rdq_count)
    );

    assign o_frontend_controller_ready = r_ready_en && !w_rdq_full;
    assign o_rdata_valid               = !w_rdq_empty;
    assign o_rdata                     = w_rdq_rdata;

    always_ff @(posedge clk) begin
        if (!power_on_rst_n) begin
            r_outstanding <= '0;
            r_err         <= 1'b0;
        end else begin
            case ({w_rd_issue, w_rdq_push})
                2'b10:   r_outstanding <= r_outstanding + 1'b1;
                2'b01:   r_outstanding <= r_outstanding - 1'b1;
                default: r_outstanding <= r_outstanding;
            endcase
            if (i_backend_read_data_valid && (r_outstanding == '0))
                r_err <= 1'b1;
        end
    end

    assign o_outstanding_reads    = r_outstanding;
    assign o_err_unexpected_rdata = r_err;

endmodule

// File: tb/tb_frontend_cmd_issue_queue.sv
// Directed bench for the frontend command issue queue.
module tb_frontend_cmd_issue_queue;
    localparam int ROW_BITS = 14;
    localparam int COL_BITS = 10;
    localparam int DATA_W   = 128;
    localparam int CB       = 1 + ROW_BITS + COL_BITS;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 req_valid;
    logic                 req_ready;
    logic                 req_op;
    logic [ROW_BITS-1:0]  req_row;
    logic [COL_BITS-1:0]  req_col;
    logic [DATA_W-1:0]    req_wdata;
    logic                 cmd_valid;
    logic [CB-1:0]        cmd;
    logic [DATA_W-1:0]    cmd_wdata;
    logic                 be_ready;
    logic [DATA_W-1:0]    be_rdata;
    logic                 be_rvalid;
    logic                 fe_ready;
    logic [DATA_W-1:0]    rdata;
    logic                 rdata_valid;
    logic                 rdata_ready;
    logic [3:0]           outstanding;
    logic                 err;

    int checks = 0;
    int errors = 0;

    frontend_cmd_issue_queue dut (
        .clk                         (clk),
        .power_on_rst_n              (rst_n),
        .i_req_valid                 (req_valid),
        .o_req_ready                 (req_ready),
        .i_req_op                    (req_op),
        .i_req_row                   (req_row),
        .i_req_col                   (req_col),
        .i_req_wdata                 (req_wdata),
        .o_frontend_command_valid    (cmd_valid),
        .o_frontend_command          (cmd),
        .o_frontend_write_data       (cmd_wdata),
        .i_backend_controller_ready  (be_ready),
        .i_backend_read_data         (be_rdata),
        .i_backend_read_data_valid   (be_rvalid),
        .o_frontend_controller_ready (fe_ready),
        .o_rdata                     (rdata),
        .o_rdata_valid               (rdata_valid),
        .i_rdata_ready               (rdata_ready),
        .o_outstanding_reads         (outstanding),
        .o_err_unexpected_rdata      (err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp_v);
        end
    endtask

    task automatic push(input logic op, input logic [ROW_BITS-1:0] row,
                        input logic [COL_BITS-1:0] col, input logic [DATA_W-1:0] wd);
        req_valid = 1'b1; req_op = op; req_row = row; req_col = col; req_wdata = wd;
        step();
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 0; req_op = 0; req_row = 0; req_col = 0; req_wdata = 0;
        be_ready = 0; be_rdata = 0; be_rvalid = 0; rdata_ready = 0;
        step(); step();
        checks++;
        if ({req_ready, cmd_valid, fe_ready, rdata_valid, err} !== 5'b0 || outstanding !== 4'd0) begin
            errors++;
            $display("FAIL reset_flags actual=%b/%0d expected=0", {req_ready, cmd_valid, fe_ready, rdata_valid, err}, outstanding);
        end
        rst_n = 1'b1;
        step();
        chk("ready_after_reset", {req_ready, fe_ready}, 2'b11);
    endtask

    task automatic test_single_write();
        be_ready = 1'b1;
        push(1'b0, 14'h12, 10'h08, {16{8'hA5}});
        chk("wr_valid", cmd_valid, 1'b1);
        chk("wr_cmd", cmd, {1'b0, 14'h12, 10'h08});
        chk("wr_data", cmd_wdata, {16{8'hA5}});
        step();
        chk("wr_issued", cmd_valid, 1'b0);
        chk("wr_outstanding", outstanding, 0);
    endtask

    task automatic test_fill_cmdq();
        be_ready = 1'b0;
        for (int i = 0; i < 8; i++) push(1'b0, 14'(i), 10'h3, 128'(i + 16));
        chk("cmdq_full_ready", req_ready, 1'b0);
        push(1'b0, 14'h3ff, 10'h3, 128'h99);
        be_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (cmd_valid !== 1'b1 || cmd !== {1'b0, 14'(i), 10'h3} || cmd_wdata !== 128'(i + 16)) begin
                errors++;
                $display("FAIL inorder_%0d actual=%b/%0h expected=1/%0h", i, cmd_valid, cmd, {1'b0, 14'(i), 10'h3});
            end
            step();
        end
        chk("ninth_dropped", cmd_valid, 1'b0);
    endtask

    task automatic test_credits();
        for (int i = 0; i < 9; i++) push(1'b1, 14'(12'h100 + i), 10'h1, '0);
        push(1'b0, 14'h2aa, 10'h2, 128'h5);
        step(); step();
        chk("credit_outstanding8", outstanding, 8);
        chk("credit_blocked", cmd_valid, 1'b0);
        be_rvalid = 1'b1; be_rdata = 128'hD0;
        step();
        be_rvalid = 1'b0;
        chk("ret_outstanding7", outstanding, 7);
        chk("ret_rdata", rdata, 128'hD0);
        chk("still_blocked", cmd_valid, 1'b0);
        rdata_ready = 1'b1;
        step();
        rdata_ready = 1'b0;
        chk("resume_valid", cmd_valid, 1'b1);
        chk("resume_cmd", cmd, {1'b1, 14'h108, 10'h1});
        step();
        chk("write_behind_valid", cmd_valid, 1'b1);
        chk("write_behind_cmd", cmd, {1'b0, 14'h2aa, 10'h2});
        step();
        chk("after_write_outst", outstanding, 8);
        for (int i = 0; i < 5; i++) begin
            be_rvalid = 1'b1; be_rdata = 128'(8'hE0 + i);
            step();
        end
        be_rvalid = 1'b0;
        chk("outstanding3", outstanding, 3);
        rdata_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("rdq_order", rdata, 128'(8'hE0 + i));
            step();
        end
        rdata_ready = 1'b0;
        chk("rdq_drained", rdata_valid, 1'b0);
    endtask

    task automatic test_same_cycle();
        be_ready = 1'b0;
        push(1'b1, 14'h55, 10'h0, '0);
        chk("sc_valid", cmd_valid, 1'b1);
        be_ready = 1'b1; be_rvalid = 1'b1; be_rdata = 128'hF0;
        step();
        be_rvalid = 1'b0;
        chk("sc_outstanding", outstanding, 3);
        chk("sc_rdata", {rdata_valid, rdata}, {1'b1, 128'hF0});
        rdata_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            be_rvalid = 1'b1; be_rdata = 128'(i);
            step();
        end
        be_rvalid = 1'b0;
        step(); step();
        rdata_ready = 1'b0;
        chk("drain_outstanding", outstanding, 0);
        chk("drain_rdq", rdata_valid, 1'b0);
    endtask

    task automatic test_unexpected();
        be_rvalid = 1'b1; be_rdata = 128'h77;
        step();
        be_rvalid = 1'b0;
        chk("unexp_err", err, 1'b1);
        chk("unexp_dropped", rdata_valid, 1'b0);
        step(); step(); step();
        chk("err_sticky", err, 1'b1);
    endtask

    task automatic test_reset_midop();
        be_ready = 1'b1;
        push(1'b1, 14'h10, 10'h0, '0);
        push(1'b1, 14'h11, 10'h0, '0);
        step(); step();
        be_ready = 1'b0;
        for (int i = 0; i < 4; i++) push(1'b0, 14'(i + 32), 10'h0, 128'hBEEF);
        chk("pre_rst_outst", outstanding, 2);
        chk("pre_rst_valid", cmd_valid, 1'b1);
        rst_n = 1'b0;
        step();
        checks++;
        if ({req_ready, cmd_valid, fe_ready, rdata_valid, err} !== 5'b0 || outstanding !== 4'd0 ||
            cmd !== '0 || cmd_wdata !== '0 || rdata !== '0) begin
            errors++;
            $display("FAIL midop_reset actual=%b/%0d/%0h expected=0", {req_ready, cmd_valid, fe_ready, rdata_valid, err}, outstanding, cmd);
        end
        rst_n = 1'b1;
        be_ready = 1'b1;
        step();
        chk("post_rst_ready", req_ready, 1'b1);
        chk("post_rst_err", err, 1'b0);
        step(); step();
        chk("post_rst_no_stale", {cmd_valid, rdata_valid}, 2'b00);
        chk("post_rst_outst", outstanding, 0);
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_fill_cmdq();
        test_credits();
        test_same_cycle();
        test_unexpected();
        test_reset_midop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
